// File: rtl/cla_response_checker.sv
// cla_response_checker: recomputes {cout, sum} for each adder vector, counts
// vectors and mismatches, captures the first failing vector and reports a
// pass/fail verdict once the vector marked last has been checked.
// Optional build macro: CLA_CHK_STOP_ON_FAIL_EN - end the session on the
// first mismatch and discard whatever is still in stage 1.
//
// state | meaning
// IDLE  | waiting for start, not accepting vectors
// RUN   | accepting one vector per cycle
// DRAIN | last vector accepted, waiting for the pipeline to empty
// DONE  | verdict valid, waiting for start
module cla_response_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_cout,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic             xfer;
  logic             clear;
  logic             mismatch;
  logic             stop_hit;
  logic [WIDTH:0]   exp_res;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
  logic             s1_cin, s1_cout;

  assign xfer     = in_valid && in_ready;
  assign clear    = start && ((state == IDLE) || (state == DONE));
  assign exp_res  = (WIDTH+1)'(s1_a) + (WIDTH+1)'(s1_b) + (WIDTH+1)'(s1_cin);
  assign mismatch = s1_valid && (exp_res != {s1_cout, s1_sum});
  assign done     = (state == DONE);
  assign pass     = done && (err_count == '0);

`ifdef CLA_CHK_STOP_ON_FAIL_EN
  // Only the first mismatch of a session ends it; fail_valid marks it as seen.
  assign stop_hit = mismatch && !fail_valid;
`else
  assign stop_hit = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (stop_hit)              state_nxt = DONE;
        else if (xfer && in_last)  state_nxt = DRAIN;
      end
      DRAIN:   if (stop_hit || !s1_valid) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; in_ready is registered from the next state so it never
  // depends on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == RUN);
    end
  end

  // Stage 1: register the accepted vector; a stop discards anything landing here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_sum   <= '0;
      s1_cout  <= 1'b0;
    end else begin
      s1_valid <= xfer && !stop_hit;
      if (xfer) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_cin  <= cin;
        s1_sum  <= sum;
        s1_cout <= cout;
      end
    end
  end

  // Stage 2: saturating counters and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_sum   <= '0;
      fail_cout  <= 1'b0;
    end else if (clear) begin
      vec_count  <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_sum   <= '0;
      fail_cout  <= 1'b0;
    end else if (s1_valid) begin
      if (vec_count != '1) vec_count <= vec_count + CNT_W'(1);
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= s1_a;
          fail_b     <= s1_b;
          fail_cin   <= s1_cin;
          fail_sum   <= s1_sum;
          fail_cout  <= s1_cout;
        end
      end
    end
  end

endmodule

// File: doc/cla_response_checker.md
# cla_response_checker

Synthesizable response checker for the ripple/carry-lookahead adder family. It sits on the output side of an adder under test: it accepts one `{a, b, cin, sum, cout}` vector per handshake and recomputes the expected `{cout, sum}`. It compares the two, counts vectors and mismatches, and captures the first failing vector. It then reports a pass/fail verdict after the vector marked `last`.

## Interface
- `WIDTH`, 4, operand width of the adder under test
- `CNT_W`, 8, width of the vector and error counters
- `clk` input 1 — single clock, rising-edge
- `rst_n` input 1 — reset, asynchronous and active-low
- `start` input 1 — one-cycle pulse; begins a check session; honoured only in IDLE or DONE
- `in_valid` input 1 — vector on inputs is valid
- `in_ready` output 1 — checker accepts a vector this cycle
- `in_last` input 1 — qualifies the final vector of the session
- `a`, `b` input WIDTH — adder operands
- `cin` input 1 — adder carry-in
- `sum` input WIDTH — adder sum under test
- `cout` input 1 — adder carry-out under test
- `vec_count` output CNT_W — vectors compared, saturating
- `err_count` output CNT_W — mismatches, saturating
- `fail_valid` output 1 — first-failure capture holds data
- `fail_a`, `fail_b` output WIDTH; `fail_cin` output 1 — operands of the first mismatch
- `fail_sum` output WIDTH; `fail_cout` output 1 — observed outputs of the first mismatch
- `done` output 1 — session complete, verdict valid
- `pass` output 1 — valid when `done`; 1 iff `err_count == 0`

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: `in_ready` = 0. On `start`, clear the counters, `fail_*` and `fail_valid`, then go to RUN.
- RUN: `in_ready` = 1. A transfer occurs when `in_valid && in_ready`. If the transfer has `in_last`, go to DRAIN; `in_ready` drops the next cycle.
- DRAIN: `in_ready` = 0. Wait until the pipeline holds no valid vector, then go to DONE.
- DONE: `done` = 1, `pass` = (`err_count == 0`). Hold until `start`, which behaves as it does in IDLE.
- `start` is ignored in RUN and DRAIN.
- Pipeline stage 1 registers the accepted vector and a valid bit. Stage 2 computes `exp = a + b + cin` at WIDTH+1 bits and compares it with `{cout, sum}`.
- On each stage-2 valid, `vec_count` increments. On a mismatch, `err_count` also increments.
- Both counters saturate at all-ones and never wrap.
- On the first mismatch only, load the `fail_*` registers and set `fail_valid`. Later mismatches leave the capture untouched.
- Reset values: FSM = IDLE; all outputs 0, including `in_ready`, `done`, `pass`, `fail_valid`, the counters and `fail_*`.
- Asserting `rst_n` low mid-session aborts immediately: outputs return to their reset values and pipeline valid bits clear.

## Timing
- Throughput is one vector per cycle in RUN.
- Latency: for a vector accepted at edge N, stage 1 registers it at edge N and stage 2 updates the counters and capture at edge N+1. Updated values are visible from the cycle after N+1.
- For a `last` vector accepted at edge N, the FSM enters DRAIN at N and DONE at N+2. `done` and `pass` are therefore high from the cycle after edge N+2.
- `in_ready` is a registered function of the state only; it never depends on `in_valid`.
- When a mismatch occurs in the cycle the FSM reaches DONE, the counters are final before `done` is visible.

## Configuration
- `CLA_CHK_STOP_ON_FAIL_EN` defined: the first stage-2 mismatch forces DONE on the following edge. `in_ready` drops immediately and `pass` = 0. Any vector already in stage 1 is discarded and not counted.
- Not defined: every vector is checked until `in_last`, and all mismatches are counted.

## Test plan
- Correct vectors `1011+0001 c0 -> 1100/0`, `0011+1011 c0 -> 1110/0`, `1001+1101 c0 -> 0110/1` (last) -> `vec_count`=3, `err_count`=0, `done`=1 and `pass`=1, three cycles after the last transfer.
- Mismatch: `1001+1101 c0` with `sum`=0111, `cout`=1, then a second bad vector -> `err_count`=2, `fail_valid`=1, and `fail_a`=1001, `fail_b`=1101, `fail_sum`=0111 from the first bad vector; `pass`=0.
- Carry-in and wrap: `1111+0000 c1` with observed 0000/1 -> counted as correct; the same vector with observed cout=0 -> mismatch.
- Saturation: `CNT_W`=2 with five bad vectors -> `vec_count`=3 and `err_count`=3, with no wrap.
- Reset mid-session: `rst_n` low while in RUN with two vectors in flight -> all outputs read 0 while reset is held; after release the FSM is in IDLE and `in_ready`=0 until `start`.
- With `CLA_CHK_STOP_ON_FAIL_EN` defined: send a good vector, then a bad vector, then a good vector back-to-back -> `done`=1, `pass`=0, `vec_count`=2 and `err_count`=1; the third vector is not counted.
